// File: rtl/cycle_ctrl_pkg.sv
// Shared types and defaults for the cycle_ctrl block.
// State encoding is fixed: software reads the state bits directly.
package cycle_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam int unsigned CNT_W_DEF   = 16;
   localparam int unsigned NUM_EVT_DEF = 3;

endpackage

// File: rtl/cycle_ctrl_if.sv
// Control/status bundle for cycle_ctrl: the master drives start/stop/clear/limit/evt,
// the slave (cycle_ctrl) returns counts, state and flags.
interface cycle_ctrl_if
   import cycle_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned NUM_EVT = NUM_EVT_DEF
) ();

   logic                     start;
   logic                     stop;
   logic                     clear;
   logic [CNT_W-1:0]         limit;
   logic [NUM_EVT-1:0]       evt;
   logic [CNT_W-1:0]         cycle;
   logic [NUM_EVT*CNT_W-1:0] evt_cnt;
   state_t                   state;
   logic                     done;
   logic                     done_pulse;
   logic [NUM_EVT:0]         ovf;

   modport master (
      output start, stop, clear, limit, evt,
      input  cycle, evt_cnt, state, done, done_pulse, ovf
   );

   modport slave (
      input  start, stop, clear, limit, evt,
      output cycle, evt_cnt, state, done, done_pulse, ovf
   );

endinterface

// File: rtl/cycle_ctrl_evt_counter.sv
// evt_counter: one counter with sticky overflow flag and synchronous clear.
// With CYCLE_CTRL_SAT_EN defined the count holds at all-ones, otherwise it wraps.
module evt_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   logic at_max;

   assign at_max = (cnt == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (inc) begin
         if (at_max) begin
            ovf <= 1'b1;
`ifdef CYCLE_CTRL_SAT_EN
            cnt <= cnt;
`else
            cnt <= '0;
`endif
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cycle_ctrl.sv
// cycle_ctrl: IDLE/RUN/PAUSE/DONE run controller with cycle and per-channel event counters.
// Define CYCLE_CTRL_SAT_EN to make every counter saturate instead of wrapping.
module cycle_ctrl
   import cycle_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned NUM_EVT = NUM_EVT_DEF
) (
   input logic         clk,
   input logic         rst,
   cycle_ctrl_if.slave bus
);

   state_t                   st;
   logic                     done_r;
   logic                     done_pulse_r;
   logic [CNT_W-1:0]         cycle_w;
   logic [NUM_EVT*CNT_W-1:0] evt_cnt_w;
   logic [NUM_EVT:0]         ovf_w;
   logic                     in_run;
   logic                     lim_on;
   logic                     lim_low;
   logic                     lim_hit;
   logic                     cycle_inc;

   assign in_run  = (st == RUN);
   assign lim_on  = (bus.limit != '0);
   // lim_low covers a limit lowered below the count mid-run: finish without counting
   assign lim_low = lim_on && (bus.limit <= cycle_w);
   assign lim_hit = lim_on && ((cycle_w + CNT_W'(1)) == bus.limit);
   assign cycle_inc = in_run && !lim_low;

   evt_counter #(.CNT_W(CNT_W)) u_cycle (
      .clk (clk),
      .rst (rst),
      .clr (bus.clear),
      .inc (cycle_inc),
      .cnt (cycle_w),
      .ovf (ovf_w[0])
   );

   for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
      evt_counter #(.CNT_W(CNT_W)) u_evt (
         .clk (clk),
         .rst (rst),
         .clr (bus.clear),
         .inc (in_run && bus.evt[i]),
         .cnt (evt_cnt_w[i*CNT_W +: CNT_W]),
         .ovf (ovf_w[i+1])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st           <= IDLE;
         done_r       <= 1'b0;
         done_pulse_r <= 1'b0;
      end else begin
         done_pulse_r <= 1'b0;
         if (bus.clear) begin
            st     <= IDLE;
            done_r <= 1'b0;
         end else begin
            case (st)
               IDLE: begin
                  if (!bus.stop && bus.start) st <= RUN;
               end
               RUN: begin
                  // reaching the limit wins over a simultaneous stop
                  if (lim_low || lim_hit) begin
                     st           <= DONE;
                     done_r       <= 1'b1;
                     done_pulse_r <= 1'b1;
                  end else if (bus.stop) begin
                     st <= PAUSE;
                  end
               end
               PAUSE: begin
                  if (!bus.stop && bus.start) st <= RUN;
               end
               DONE: begin
                  st <= DONE;
               end
               default: st <= IDLE;
            endcase
         end
      end
   end

   assign bus.state      = st;
   assign bus.cycle      = cycle_w;
   assign bus.evt_cnt    = evt_cnt_w;
   assign bus.ovf        = ovf_w;
   assign bus.done       = done_r;
   assign bus.done_pulse = done_pulse_r;

endmodule

// File: tb/tb_cycle_ctrl.sv
// Bench for cycle_ctrl: directed steps on a 16-bit instance, then wrap and
// randomized checks of a 4-bit instance against an unbounded-count reference model.
module tb_cycle_ctrl;

   localparam int unsigned NE = 3;
`ifdef CYCLE_CTRL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   cycle_ctrl_if #(.CNT_W(16), .NUM_EVT(NE)) b16 ();
   cycle_ctrl_if #(.CNT_W(4),  .NUM_EVT(NE)) b4 ();

   cycle_ctrl #(.CNT_W(16), .NUM_EVT(NE)) dut16 (.clk(clk), .rst(rst), .bus(b16));
   cycle_ctrl #(.CNT_W(4),  .NUM_EVT(NE)) dut4  (.clk(clk), .rst(rst), .bus(b4));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: true (unbounded) counts, displayed through a 4-bit window.
   int m_st;
   int m_cyc;
   int m_ev[NE];
   bit m_dp;

   function automatic int shown(input int n);
      if (SAT) return (n > 15) ? 15 : n;
      return n % 16;
   endfunction

   task automatic model_edge(input bit s, input bit p, input bit c, input int lim, input logic [NE-1:0] e);
      m_dp = 1'b0;
      if (c) begin
         m_st = 0; m_cyc = 0;
         for (int i = 0; i < NE; i++) m_ev[i] = 0;
      end else if (m_st == 0 || m_st == 2) begin
         if (!p && s) m_st = 1;
      end else if (m_st == 1) begin
         for (int i = 0; i < NE; i++) if (e[i]) m_ev[i]++;
         if (lim != 0 && lim <= shown(m_cyc)) begin
            m_st = 3; m_dp = 1'b1;
         end else begin
            m_cyc++;
            if (lim != 0 && shown(m_cyc) == lim) begin
               m_st = 3; m_dp = 1'b1;
            end else if (p) begin
               m_st = 2;
            end
         end
      end
   endtask

   initial begin
      int found;
      int lat;
      int cur_lim;
      logic [11:0] exp_ev;
      logic [3:0]  exp_ovf;

      rst = 1'b1;
      b16.start = 1'b0; b16.stop = 1'b0; b16.clear = 1'b0; b16.limit = '0; b16.evt = '0;
      b4.start  = 1'b0; b4.stop  = 1'b0; b4.clear  = 1'b0; b4.limit  = '0; b4.evt  = '0;
      step(); step();
      check("rst_state", b16.state, 0);
      check("rst_cycle", b16.cycle, 0);
      check("rst_evt", b16.evt_cnt, 0);
      check("rst_ovf", b16.ovf, 0);
      check("rst_done", {b16.done, b16.done_pulse}, 0);
      rst = 1'b0;
      step();

      // limit 2000: done_pulse 2001 cycles after the start cycle
      b16.limit = 16'd2000; b16.start = 1'b1;
      step();
      b16.start = 1'b0;
      found = 0; lat = 0;
      for (int k = 1; k <= 3000 && found == 0; k++) begin
         step();
         if (b16.done_pulse === 1'b1) begin found = 1; lat = k + 1; end
      end
      check("lim_latency", lat, 2001);
      check("lim_cycle", b16.cycle, 2000);
      check("lim_state", b16.state, 3);
      check("lim_done", b16.done, 1);
      b16.start = 1'b1; b16.stop = 1'b1;
      step();
      b16.start = 1'b0; b16.stop = 1'b0;
      check("done_pulse_once", b16.done_pulse, 0);
      check("done_sticky_st", b16.state, 3);
      check("done_sticky_cyc", b16.cycle, 2000);
      b16.clear = 1'b1;
      step();
      b16.clear = 1'b0;
      check("clr_state", b16.state, 0);
      check("clr_cycle", b16.cycle, 0);
      check("clr_done", b16.done, 0);

      // events counted only in RUN
      b16.limit = '0; b16.start = 1'b1;
      step();
      b16.start = 1'b0; b16.evt = 3'b001;
      repeat (5) step();
      b16.evt = '0;
      check("ev_run5", b16.evt_cnt, 48'd5);
      check("ev_cyc5", b16.cycle, 5);
      b16.stop = 1'b1;
      step();
      b16.stop = 1'b0;
      check("pause_state", b16.state, 2);
      check("pause_cycle", b16.cycle, 6);
      b16.evt = 3'b001;
      repeat (3) step();
      b16.evt = '0;
      check("ev_pause_drop", b16.evt_cnt, 48'd5);
      b16.start = 1'b1;
      step();
      b16.start = 1'b0;
      check("resume_state", b16.state, 1);
      check("resume_ev", b16.evt_cnt, 48'd5);
      check("resume_cyc", b16.cycle, 6);
      step();
      check("run_cyc7", b16.cycle, 7);

      // clear beats stop and start
      b16.clear = 1'b1; b16.stop = 1'b1; b16.start = 1'b1;
      step();
      b16.clear = 1'b0; b16.stop = 1'b0; b16.start = 1'b0;
      check("prio_state", b16.state, 0);
      check("prio_cycle", b16.cycle, 0);
      check("prio_evt", b16.evt_cnt, 0);
      check("prio_ovf", b16.ovf, 0);

      // stop on the limit edge still finishes
      b16.limit = 16'd5; b16.start = 1'b1;
      step();
      b16.start = 1'b0;
      repeat (4) step();
      check("stoplim_cyc4", b16.cycle, 4);
      b16.stop = 1'b1;
      step();
      b16.stop = 1'b0;
      check("stoplim_state", b16.state, 3);
      check("stoplim_cycle", b16.cycle, 5);
      check("stoplim_pulse", b16.done_pulse, 1);
      b16.clear = 1'b1; step(); b16.clear = 1'b0;

      // limit lowered below the count mid-run
      b16.limit = 16'd100; b16.start = 1'b1;
      step();
      b16.start = 1'b0;
      repeat (20) step();
      check("lower_cyc20", b16.cycle, 20);
      b16.limit = 16'd10;
      step();
      check("lower_state", b16.state, 3);
      check("lower_cycle", b16.cycle, 20);
      check("lower_pulse", b16.done_pulse, 1);
      b16.clear = 1'b1; step(); b16.clear = 1'b0;

      // asynchronous reset between edges at cycle 37
      b16.limit = '0; b16.evt = 3'b010; b16.start = 1'b1;
      step();
      b16.start = 1'b0;
      repeat (37) step();
      check("arst_cyc37", b16.cycle, 37);
      check("arst_ev37", b16.evt_cnt, {16'd0, 16'd37, 16'd0});
      #2 rst = 1'b1;
      #1;
      check("arst_state", b16.state, 0);
      check("arst_cycle", b16.cycle, 0);
      check("arst_evt", b16.evt_cnt, 0);
      check("arst_flags", {b16.ovf, b16.done, b16.done_pulse}, 0);
      rst = 1'b0; b16.evt = '0;
      repeat (3) step();
      check("arst_no_resume", {b16.state, b16.cycle}, 0);

      // 4-bit wrap/saturate over 17 RUN edges
      b4.limit = '0; b4.start = 1'b1;
      step();
      b4.start = 1'b0;
      repeat (16) step();
      b4.stop = 1'b1;
      step();
      b4.stop = 1'b0;
      check("w4_cycle", b4.cycle, SAT ? 15 : 1);
      check("w4_ovf0", b4.ovf[0], 1);
      check("w4_state", b4.state, 2);
      b4.clear = 1'b1;
      step();
      b4.clear = 1'b0;
      check("w4_clr_ovf", b4.ovf, 0);
      check("w4_clr_cyc", b4.cycle, 0);

      // randomized run against the model
      m_st = 0; m_cyc = 0; m_dp = 1'b0;
      for (int i = 0; i < NE; i++) m_ev[i] = 0;
      cur_lim = 0;
      for (int k = 0; k < 600; k++) begin
         b4.clear = ($urandom_range(0, 39) == 0);
         b4.stop  = ($urandom_range(0, 9) == 0);
         b4.start = ($urandom_range(0, 3) == 0);
         b4.evt   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0)
            cur_lim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
         b4.limit = 4'(cur_lim);
         @(posedge clk);
         model_edge(b4.start, b4.stop, b4.clear, cur_lim, b4.evt);
         #1;
         for (int i = 0; i < NE; i++) exp_ev[i*4 +: 4] = 4'(shown(m_ev[i]));
         exp_ovf[0] = (m_cyc > 15);
         for (int i = 0; i < NE; i++) exp_ovf[i+1] = (m_ev[i] > 15);
         check("rnd_state", b4.state, m_st);
         check("rnd_cycle", b4.cycle, shown(m_cyc));
         check("rnd_evt", b4.evt_cnt, exp_ev);
         check("rnd_ovf", b4.ovf, exp_ovf);
         check("rnd_done", b4.done, (m_st == 3));
         check("rnd_pulse", b4.done_pulse, m_dp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cycle_ctrl.md
CYCLE_CTRL -- requirements
Module: cycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of cycle and event counters.
REQ-002 SHALL have parameter NUM_EVT, default 3, number of event channels (e.g. write_mode, doubleRead, doubleWrite).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin or resume counting.
REQ-006 SHALL have port stop  input  1  pause counting.
REQ-007 SHALL have port clear  input  1  synchronous return to idle with all counters zeroed.
REQ-008 SHALL have port limit  input  CNT_W  run length in cycles; 0 means unlimited.
REQ-009 SHALL have port evt  input  NUM_EVT  per-channel event strobes.
REQ-010 SHALL have port cycle  output  CNT_W  elapsed RUN cycles.
REQ-011 SHALL have port evt_cnt  output  NUM_EVT*CNT_W  packed per-channel counts; channel i at bits [i*CNT_W +: CNT_W].
REQ-012 SHALL have port state  output  2  current FSM state.
REQ-013 SHALL have port done  output  1  high while in DONE.
REQ-014 SHALL have port done_pulse  output  1  one-cycle strobe on entry to DONE.
REQ-015 SHALL have port ovf  output  NUM_EVT+1  sticky overflow flags; bit 0 cycle, bit i+1 channel i.

Function
REQ-016 SHALL implement FSM states IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-017 SHALL apply input priority clear > stop > start when asserted in the same cycle.
REQ-018 SHALL transition IDLE->RUN on start, RUN->PAUSE on stop, and PAUSE->RUN on start.
REQ-019 SHALL transition any state->IDLE on clear, zeroing cycle, evt_cnt and ovf on the same edge.
REQ-020 SHALL ignore start and stop in DONE; only clear or rst leaves DONE.
REQ-021 SHALL increment cycle by 1 on every edge where state==RUN; the new value is visible the following cycle.
REQ-022 SHALL not count the start edge itself: the first increment occurs on the edge after entry to RUN.
REQ-023 SHALL increment evt_cnt[i] on every edge where state==RUN and evt[i]==1; events in IDLE, PAUSE and DONE are dropped.
REQ-024 SHALL, when limit!=0 and the edge increments cycle to limit, enter DONE on that same edge, with cycle==limit and done_pulse high for exactly the next cycle.
REQ-025 SHALL sample limit every cycle; if limit<=cycle while in RUN (lowered mid-run), it SHALL enter DONE on the next edge without incrementing.
REQ-026 SHALL set the counter's ovf bit when that counter would exceed 2^CNT_W-1; ovf bits stay set until clear or rst.
REQ-027 SHALL, with stop asserted in the same cycle the limit is reached, enter DONE (limit takes precedence over stop).

Reset
REQ-028 SHALL, on rst assertion and independently of clk, force state=IDLE, cycle=0, evt_cnt=0, ovf=0, done=0, done_pulse=0.
REQ-029 SHALL, on reset mid-run, discard all counts; after release, counting resumes only on a new start.

Configuration
REQ-030 SHALL support macro CYCLE_CTRL_SAT_EN: when defined, counters saturate at 2^CNT_W-1 (ovf still sets); when undefined, counters wrap to 0.

Structure
REQ-031 SHALL place the state encoding typedef and the state constants in package cycle_ctrl_pkg.
REQ-032 SHALL instantiate one sub-module evt_counter per event channel via generate; it contains the counter, the ovf bit and the saturation logic.

Verification
REQ-033 SHALL cover: CNT_W=16, limit=2000, start pulse -> done_pulse exactly 2001 cycles after start, cycle==2000, state==DONE.
REQ-034 SHALL cover: evt[0] high for 5 RUN cycles, stop, evt[0] high 3 more cycles, start -> evt_cnt[0]==5 until next RUN event.
REQ-035 SHALL cover: clear, stop and start asserted together in RUN -> state==IDLE, all counters 0 next cycle.
REQ-036 SHALL cover: CNT_W=4, limit=0, 17 RUN cycles -> cycle==1 with ovf[0]=1 (wrap), or cycle==15 with ovf[0]=1 when CYCLE_CTRL_SAT_EN.
REQ-037 SHALL cover: rst asserted between clock edges at cycle==37 -> all outputs zero before the next rising edge.
REQ-038 SHALL cover: limit lowered from 100 to 10 at cycle==20 -> DONE next edge, cycle==20.
